pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard/sequencing controller for the 5-stage pipelined CPU (IF, ID, EX, MEM, WB).
- Tracks destination-register info for the EX, MEM and WB stages internally.
- From that tracking it drives ID-stage forwarding selects, load-use stalls, taken-branch flushes and global freezes on data-memory busy.
- Keeps cycle-accurate stall and retire counters for performance checking.

Parameters:
REG_W, 5, register-number width
CNT_W, 32, performance counter width

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_W  ID source register A
id_rt  in  REG_W  ID source register B
id_rs_used  in  1  instruction reads rs
id_rt_used  in  1  instruction reads rt
id_wreg  in  1  instruction writes a register
id_rn  in  REG_W  ID destination register
id_m2reg  in  1  instruction is a load
br_taken  in  1  branch resolved taken in EX this cycle
mem_busy  in  1  data memory not ready this cycle
fwda  out  2  forward select A: 0 regfile, 1 EX ALU result, 2 MEM ALU result, 3 MEM load data
fwdb  out  2  forward select B, same encoding
stall  out  1  hold PC and IF/ID register
bubble  out  1  load a NOP into ID/EX
flush  out  1  squash IF/ID contents
freeze  out  1  hold every pipeline register
stall_cnt  out  CNT_W  cycles in which stall or freeze was high
retire_cnt  out  CNT_W  valid register-writing or non-writing instructions leaving WB

Behaviour:
- Internal stage records: EX, MEM and WB each hold {valid, wreg, rn, m2reg}. On reset all four fields clear to 0.
- Reset output values:
  - Counters reset to 0.
  - Combinational outputs follow from cleared state: fwda=fwdb=0, stall=bubble=flush=0, freeze=mem_busy.
- Forwarding is combinational and computed for rs and rt independently:
  - Forward from EX: EX.valid & EX.wreg & EX.rn!=0 & EX.rn==src & !EX.m2reg -> 1.
  - Else forward from MEM: MEM.valid & MEM.wreg & MEM.rn!=0 & MEM.rn==src. Result is 3 if MEM.m2reg, otherwise 2.
  - Else 0.
  - EX has priority over MEM. Register 0 is never forwarded. An unused source (id_*_used=0) always gives 0.
- Load-use hazard:
  - lu = id_valid & EX.valid & EX.m2reg & EX.wreg & EX.rn!=0 & ((id_rs_used & EX.rn==id_rs) | (id_rt_used & EX.rn==id_rt)).
  - stall = lu & !br_taken & !mem_busy.
  - bubble = stall | flush.
- Branch: flush = br_taken & !mem_busy. A taken branch overrides lu: the ID instruction is squashed, so no stall is needed.
- freeze = mem_busy. While frozen, no stage record advances and no counter changes except stall_cnt. stall, bubble and flush are forced to 0 during freeze.
- Advance on a rising clk edge when !freeze:
  - EX <= ID fields with valid = id_valid & !bubble.
  - MEM <= EX.
  - WB <= MEM.
- Latency: forwarding and stall outputs respond in the same cycle as their inputs. State updates one edge later.
- Counters:
  - stall_cnt increments every cycle where (stall | freeze).
  - retire_cnt increments on each non-frozen edge where WB.valid=1.
  - Both wrap modulo 2^CNT_W.
- Reset mid-operation: clr asserted at any time clears all records and counters immediately, independent of clk. The first edge after release behaves as a fresh start.
- A load-use stall lasts exactly one cycle, because the load moves to MEM and the hazard then resolves through fwd=3.

Test Plan:
- Reset: clr=1 at t=0, release at 50 ns with idle inputs -> all outputs 0, counters 0 after 10 edges except retire_cnt=0.
- ALU back-to-back: issue add r3 (wreg, rn=3), then sub reading rs=3 -> fwda=1 during the second instruction's ID cycle. A third instruction reading r3 one cycle later -> fwda=2.
- Load-use: lw r5 followed by an add using rt=5 -> stall=1 and bubble=1 for exactly one cycle, then fwdb=3 in the next cycle, stall_cnt=1.
- Branch vs load-use: EX holds a load to r5, ID reads r5, br_taken=1 in the same cycle -> flush=1, bubble=1, stall=0, and the EX record becomes invalid after the edge.
- mem_busy for 3 cycles mid-stream -> freeze=1, stage records unchanged, retire_cnt held, stall_cnt += 3, fwd selects stable.
- r0 and unused sources: writer to r0 followed by a reader of r0 -> fwda=0, no stall. A load to r7 with ID rt=7 but id_rt_used=0 -> stall=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: tracks EX/MEM/WB destination
// info and produces ID forwarding selects, load-use stalls, branch flushes and freezes.
module pipe_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_wreg,
    input  logic [REG_W-1:0] id_rn,
    input  logic             id_m2reg,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef struct packed {
        logic             valid;
        logic             wreg;
        logic [REG_W-1:0] rn;
        logic             m2reg;
    } rec_t;

    rec_t ex_r, mem_r, wb_r;
    rec_t ex_nxt;
    logic lu;

    // EX wins over MEM; an EX load cannot forward yet and is handled by the load-use stall.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_W-1:0] src,
                                           input rec_t ex, input rec_t mem);
        logic [1:0] sel;
        sel = 2'd0;
        if (used) begin
            if (ex.valid && ex.wreg && ex.rn != '0 && ex.rn == src && !ex.m2reg)
                sel = 2'd1;
            else if (mem.valid && mem.wreg && mem.rn != '0 && mem.rn == src)
                sel = mem.m2reg ? 2'd3 : 2'd2;
        end
        return sel;
    endfunction

    always_comb begin
        fwda   = fwd_sel(id_rs_used, id_rs, ex_r, mem_r);
        fwdb   = fwd_sel(id_rt_used, id_rt, ex_r, mem_r);
        lu     = id_valid && ex_r.valid && ex_r.m2reg && ex_r.wreg && ex_r.rn != '0 &&
                 ((id_rs_used && ex_r.rn == id_rs) || (id_rt_used && ex_r.rn == id_rt));
        freeze = mem_busy;
        flush  = br_taken && !mem_busy;
        stall  = lu && !br_taken && !mem_busy;
        bubble = stall || flush;
    end

    always_comb begin
        ex_nxt.valid = id_valid && !bubble;
        ex_nxt.wreg  = id_wreg;
        ex_nxt.rn    = id_rn;
        ex_nxt.m2reg = id_m2reg;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else if (!freeze) begin
            ex_r  <= ex_nxt;
            mem_r <= ex_r;
            wb_r  <= mem_r;
        end
    end

    // stall_cnt keeps counting through a freeze; retire_cnt only moves when WB actually drains.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stall_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (stall || freeze)
                stall_cnt <= stall_cnt + 1'b1;
            if (!freeze && wb_r.valid)
                retire_cnt <= retire_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a queue-of-instructions reference model.
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             clr;
    logic             id_valid, id_rs_used, id_rt_used, id_wreg, id_m2reg;
    logic [REG_W-1:0] id_rs, id_rt, id_rn;
    logic             br_taken, mem_busy;
    logic [1:0]       fwda, fwdb;
    logic             stall, bubble, flush, freeze;
    logic [CNT_W-1:0] stall_cnt, retire_cnt;

    pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wreg(id_wreg),
        .id_rn(id_rn), .id_m2reg(id_m2reg), .br_taken(br_taken), .mem_busy(mem_busy),
        .fwda(fwda), .fwdb(fwdb), .stall(stall), .bubble(bubble), .flush(flush),
        .freeze(freeze), .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // Model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        bit     valid;
        bit     wr;
        int     dst;
        bit     load;
    } instr_t;

    instr_t pipe[3];
    int unsigned m_stall_cnt, m_retire_cnt;
    int n_vec, n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit writes_reg(input instr_t i, input int r);
        return i.valid && i.wr && i.dst != 0 && i.dst == r;
    endfunction

    function automatic int model_fwd(input bit used, input int src);
        if (!used) return 0;
        if (writes_reg(pipe[0], src) && !pipe[0].load) return 1;
        if (writes_reg(pipe[1], src)) return pipe[1].load ? 3 : 2;
        return 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
        m_stall_cnt  = 0;
        m_retire_cnt = 0;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_wreg = 0; id_rn = 0; id_m2reg = 0; br_taken = 0; mem_busy = 0;
    endtask

    int ex_stall, ex_flush, ex_bubble;
    bit load_use;

    initial begin
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        model_clear();
        clr = 1'b1;
        #2;
        chk("rst_fwda", fwda, 0);
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_freeze", freeze, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_retire_cnt", retire_cnt, 0);
        #48 clr = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_stall_cnt", stall_cnt, 0);
        chk("idle_retire_cnt", retire_cnt, 0);
        chk("idle_bubble", bubble, 0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                // Asynchronous reset in mid-cycle must clear everything at once.
                clr = 1'b1;
                #1;
                chk("async_stall_cnt", stall_cnt, 0);
                chk("async_retire_cnt", retire_cnt, 0);
                clr = 1'b0;
                model_clear();
            end
            id_valid   = ($urandom_range(0, 9) != 0);
            id_rs      = REG_W'($urandom_range(0, 7));
            id_rt      = REG_W'($urandom_range(0, 7));
            id_rs_used = $urandom_range(0, 3) != 0;
            id_rt_used = $urandom_range(0, 2) != 0;
            id_wreg    = $urandom_range(0, 3) != 0;
            id_rn      = REG_W'($urandom_range(0, 7));
            id_m2reg   = ($urandom_range(0, 2) == 0);
            br_taken   = ($urandom_range(0, 9) == 0);
            mem_busy   = ($urandom_range(0, 6) == 0);
            #3;

            load_use = id_valid && pipe[0].valid && pipe[0].load &&
                       ((id_rs_used && writes_reg(pipe[0], int'(id_rs))) ||
                        (id_rt_used && writes_reg(pipe[0], int'(id_rt))));
            ex_flush  = (br_taken && !mem_busy) ? 1 : 0;
            ex_stall  = (load_use && !br_taken && !mem_busy) ? 1 : 0;
            ex_bubble = (ex_stall == 1 || ex_flush == 1) ? 1 : 0;

            chk("fwda", fwda, model_fwd(id_rs_used, int'(id_rs)));
            chk("fwdb", fwdb, model_fwd(id_rt_used, int'(id_rt)));
            chk("stall", stall, ex_stall);
            chk("flush", flush, ex_flush);
            chk("bubble", bubble, ex_bubble);
            chk("freeze", freeze, mem_busy);

            if (ex_stall == 1 || mem_busy) m_stall_cnt++;
            if (!mem_busy) begin
                if (pipe[2].valid) m_retire_cnt++;
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = '{id_valid && ex_bubble == 0, id_wreg, int'(id_rn), id_m2reg};
            end

            @(posedge clk);
            #1;
            chk("stall_cnt", stall_cnt, 64'(m_stall_cnt));
            chk("retire_cnt", retire_cnt, 64'(m_retire_cnt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
